id_ex_skid_reg: RTL and testbench
=================================

// Module: id_ex_skid_reg
// PURPOSE
//   Parametrised decode->execute pipeline register for the MISC-V core.
//   Holds the decoded bundle (pc, args, imm, reg indices, control) in a 2-entry skid buffer
//   with valid/ready handshakes on both sides, synchronous flush for jumps,
//   load-use hazard detection and a saturating stall-cycle counter.
// PARAMETERS
//   DATA_W     16  width of pc, arg1, arg2, imm
//   REG_ADDR_W 4   width of rs1/rs2/rd register indices
//   CTRL_W     10  width of packed control bundle (RegWrite, ALUSrc, ALUOp, MemWrite, ...)
//   CNT_W      16  width of stall_count
// PORTS
//   clk           in   1           rising-edge clock
//   reset         in   1           asynchronous, active-high reset
//   in_valid      in   1           decode offers a bundle
//   in_ready      out  1           block accepts the bundle this cycle
//   in_pc,in_arg1,in_arg2,in_imm  in  DATA_W each  decoded payload
//   in_rs1,in_rs2,in_rd           in  REG_ADDR_W each  register indices
//   in_ctrl       in   CTRL_W      control bundle
//   in_memread    in   1           bundle is a load
//   flush         in   1           discard all held entries (jump taken)
//   out_valid     out  1           head entry valid
//   out_ready     in   1           execute consumes head this cycle
//   out_pc..out_memread  out  same widths as in_*  head-entry payload
//   hazard_stall  out  1           load-use hazard between head and offered bundle
//   stall_count   out  CNT_W       cycles with in_valid=1 and in_ready=0
// BEHAVIOUR
//   - Reset (async): head/skid valid=0, all payload regs=0, stall_count=0. in_ready=0 while reset=1.
//   - Accept = in_valid & in_ready; drain = out_valid & out_ready.
//   - Latency: a bundle accepted in cycle N is on out_* from cycle N+1. No comb in->out path.
//   - Full throughput (1 per cycle) when out_ready is held high.
//   - in_ready = ~skid_valid & ~flush & ~hazard_stall & ~reset (combinational).
//   - Data movement per edge, in priority order:
//     - flush=1: head_valid=0, skid_valid=0. Payload regs keep their values. Any offered input is not accepted.
//     - Head empty: accept -> head.
//     - Head valid, drain, skid valid: skid -> head, skid_valid=0.
//     - Head valid, drain, skid empty: accept -> head, else head_valid=0.
//     - Head valid, no drain: accept -> skid.
//   - Order is strictly preserved. No bundle is lost or duplicated outside flush.
//   - hazard_stall = out_valid & out_memread & (out_rd!=0) & in_valid & (in_rs1==out_rd | in_rs2==out_rd).
//     - Combinational.
//     - Compared against the head only; skid occupancy already forces in_ready=0.
//   - stall_count increments on each edge where in_valid & ~in_ready & ~reset.
//     - Saturates at all-ones; it never wraps.
//     - Cleared only by reset; flush does not clear it.
//   - Reset mid-operation: both entries are dropped at once. After release, in_ready=1 on the first cycle.
// TESTING
//   1. Fill head+skid, then assert reset for 2 cycles -> out_valid=0, in_ready=0 during reset; in_ready=1, stall_count=0 after.
//   2. out_ready=1, push pc 0x0000..0x0004 back-to-back -> out_pc shows 0x0000..0x0004 one cycle later; in_ready stays 1.
//   3. out_ready=0, push pc A=0x1111, B=0x2222 -> head=A, skid=B, in_ready=0, C=0x3333 held. Release out_ready -> A, B, C in order, one per cycle.
//   4. Head+skid full, in_valid=1, flush=1 for 1 cycle -> next cycle out_valid=0, offered bundle not accepted, in_ready=1.
//   5. Head is a load with rd=3; offer in_rs2=3 -> hazard_stall=1, in_ready=0. Same with out_rd=0 -> hazard_stall=0.
//   6. CNT_W=4, hold in_valid=1, out_ready=0 for 20 cycles -> stall_count saturates at 4'hF and does not wrap.

Source files
------------

// File: rtl/id_ex_skid_reg.sv
// id_ex_skid_reg: decode->execute pipeline register with a 2-entry skid buffer,
// jump flush, load-use hazard detection and a saturating stall-cycle counter.
module id_ex_skid_reg #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int CTRL_W     = 10,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic [DATA_W-1:0]     in_arg1,
    input  logic [DATA_W-1:0]     in_arg2,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic                  in_memread,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_pc,
    output logic [DATA_W-1:0]     out_arg1,
    output logic [DATA_W-1:0]     out_arg2,
    output logic [DATA_W-1:0]     out_imm,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic                  out_memread,
    output logic                  hazard_stall,
    output logic [CNT_W-1:0]      stall_count
);
    localparam int BW = 4*DATA_W + 3*REG_ADDR_W + CTRL_W + 1;

    logic [BW-1:0]    r_head, r_skid;
    logic             r_head_v, r_skid_v;
    logic [CNT_W-1:0] r_cnt;
    logic [BW-1:0]    w_in;
    logic             w_acc, w_drain;

    assign w_in = {in_pc, in_arg1, in_arg2, in_imm, in_rs1, in_rs2, in_rd, in_ctrl, in_memread};
    assign {out_pc, out_arg1, out_arg2, out_imm, out_rs1, out_rs2, out_rd, out_ctrl, out_memread} = r_head;
    assign out_valid   = r_head_v;
    assign stall_count = r_cnt;

    // Only the head can be a pending load: a full skid already blocks input.
    assign hazard_stall = r_head_v & out_memread & (out_rd != '0) & in_valid &
                          ((in_rs1 == out_rd) | (in_rs2 == out_rd));
    assign in_ready = ~r_skid_v & ~flush & ~hazard_stall & ~reset;
    assign w_acc    = in_valid & in_ready;
    assign w_drain  = r_head_v & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head   <= '0;
            r_skid   <= '0;
            r_head_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (in_valid && !in_ready && !(&r_cnt))
                r_cnt <= r_cnt + CNT_W'(1);
            if (flush) begin
                r_head_v <= 1'b0;
                r_skid_v <= 1'b0;
            end else if (!r_head_v) begin
                if (w_acc) r_head <= w_in;
                r_head_v <= w_acc;
            end else if (w_drain && r_skid_v) begin
                r_head   <= r_skid;
                r_skid_v <= 1'b0;
            end else if (w_drain) begin
                if (w_acc) r_head <= w_in;
                r_head_v <= w_acc;
            end else if (w_acc) begin
                r_skid   <= w_in;
                r_skid_v <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb_id_ex_skid_reg: directed and random traffic, checked against a 2-deep FIFO
// reference model with a saturating stall counter.
module tb_id_ex_skid_reg;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 10;
    localparam int NW = 4;
    localparam int CMAX = (1 << NW) - 1;

    typedef struct packed {
        logic [DW-1:0] pc, a1, a2, imm;
        logic [AW-1:0] rs1, rs2, rd;
        logic [CW-1:0] ctrl;
        logic          mr;
    } bund_t;

    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    bund_t ib = '0;
    logic in_ready, out_valid, hazard_stall;
    logic [NW-1:0] stall_count;
    logic [DW-1:0] o_pc, o_a1, o_a2, o_imm;
    logic [AW-1:0] o_rs1, o_rs2, o_rd;
    logic [CW-1:0] o_ctrl;
    logic          o_mr;
    bund_t ob;
    assign ob = {o_pc, o_a1, o_a2, o_imm, o_rs1, o_rs2, o_rd, o_ctrl, o_mr};

    id_ex_skid_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(ib.pc), .in_arg1(ib.a1), .in_arg2(ib.a2), .in_imm(ib.imm),
        .in_rs1(ib.rs1), .in_rs2(ib.rs2), .in_rd(ib.rd), .in_ctrl(ib.ctrl),
        .in_memread(ib.mr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(o_pc), .out_arg1(o_a1), .out_arg2(o_a2), .out_imm(o_imm),
        .out_rs1(o_rs1), .out_rs2(o_rs2), .out_rd(o_rd), .out_ctrl(o_ctrl),
        .out_memread(o_mr), .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    bund_t q[$];
    int m_cnt = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: the expected-output queue is the model's FIFO contents; checks and
    // model update happen mid-cycle, predicting the next rising edge.
    always @(negedge clk) begin
        bit hz, rdy;
        if (reset) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_count", stall_count, 0);
            q.delete();
            m_cnt = 0;
        end else begin
            hz = q.size() > 0 && q[0].mr && q[0].rd != 0 && in_valid &&
                 (ib.rs1 == q[0].rd || ib.rs2 == q[0].rd);
            rdy = q.size() < 2 && !flush && !hz;
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, rdy);
            chk("hazard", hazard_stall, hz);
            chk("stall_count", stall_count, m_cnt);
            if (q.size() > 0) chk("payload", ob, q[0]);
            if (in_valid && !rdy && m_cnt < CMAX) m_cnt++;
            if (flush) q.delete();
            else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (in_valid && rdy) q.push_back(ib);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bund_t mk(input logic [DW-1:0] pc);
        bund_t b;
        b = '0;
        b.pc = pc;
        b.a1 = DW'($urandom);
        b.a2 = DW'($urandom);
        b.imm = DW'($urandom);
        b.rs1 = AW'($urandom);
        b.rs2 = AW'($urandom);
        b.rd = AW'($urandom);
        b.ctrl = CW'($urandom);
        return b;
    endfunction

    function automatic bund_t rnd();
        bund_t b;
        b = mk(DW'($urandom));
        b.rs1 = AW'($urandom_range(0, 3));
        b.rs2 = AW'($urandom_range(0, 3));
        b.rd = AW'($urandom_range(0, 3));
        b.mr = 1'($urandom);
        return b;
    endfunction

    task automatic push(input bund_t b);
        in_valid = 1'b1;
        ib = b;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        bund_t b;
        cyc();
        cyc();
        reset = 1'b0;
        // fill head+skid, then reset
        push(mk(16'h00a0));
        push(mk(16'h00a1));
        in_valid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("t1_rst_valid", out_valid, 0);
        cyc();
        cyc();
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_ready", in_ready, 1);
        chk("t1_cnt", stall_count, 0);
        cyc();
        // back-to-back streaming
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            ib = mk(DW'(i));
            @(negedge clk);
            chk("t2_ready", in_ready, 1);
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_last_pc", o_pc, 16'h0004);
        cyc();
        cyc();
        // skid fill and ordered release
        out_ready = 1'b0;
        push(mk(16'h1111));
        push(mk(16'h2222));
        in_valid = 1'b1;
        ib = mk(16'h3333);
        @(negedge clk);
        chk("t3_ready", in_ready, 0);
        chk("t3_head", o_pc, 16'h1111);
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_out_a", o_pc, 16'h1111);
        cyc();
        @(negedge clk);
        chk("t3_out_b", o_pc, 16'h2222);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_out_c", o_pc, 16'h3333);
        cyc();
        cyc();
        // flush with both entries full and an offer pending
        out_ready = 1'b0;
        push(mk(16'h4444));
        push(mk(16'h5555));
        in_valid = 1'b1;
        ib = mk(16'hdddd);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_valid", out_valid, 0);
        chk("t4_ready", in_ready, 1);
        cyc();
        // load-use hazard
        b = mk(16'h5a5a);
        b.mr = 1'b1;
        b.rd = 4'd3;
        push(b);
        ib = mk(16'h6666);
        ib.rs1 = 4'd5;
        ib.rs2 = 4'd3;
        in_valid = 1'b1;
        @(negedge clk);
        chk("t5_hazard", hazard_stall, 1);
        chk("t5_ready", in_ready, 0);
        cyc();
        in_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        b.rd = 4'd0;
        push(b);
        ib = mk(16'h7777);
        ib.rs1 = 4'd0;
        ib.rs2 = 4'd0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("t5_rd0_hazard", hazard_stall, 0);
        chk("t5_rd0_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        // stall counter saturation
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        ib = mk(16'h8888);
        repeat (20) cyc();
        @(negedge clk);
        chk("t6_sat", stall_count, 4'hf);
        cyc();
        in_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("t6_flush_keeps", stall_count, 4'hf);
        cyc();
        // random traffic
        repeat (3000) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 15) == 0;
            reset = $urandom_range(0, 199) == 0;
            ib = rnd();
            cyc();
        end
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
